// File: rtl/ring_dispatcher_pkg.sv
// Shared helpers for the ring dispatcher slice.
package ring_dispatcher_pkg;

  // Next index around a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/onehot_priority_encoder.sv
// Keeps only the lowest set request bit.
module onehot_priority_encoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [WIDTH-1:0] o_onehot
);

  assign o_onehot = i_req & (~i_req + WIDTH'(1));

endmodule

// File: rtl/ring_dispatcher_slot.sv
// One output register slot: holds a word until the downstream port takes it.
module ring_dispatcher_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_aresetn,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_avail
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    // A write in the same cycle as a drain keeps the slot occupied.
    if (i_wr_en)                     valid_d = 1'b1;
    else if (valid_q && i_rd_ready)  valid_d = 1'b0;
    if (i_clear)                     valid_d = 1'b0;
    data_d = i_wr_en ? i_wr_data : data_q;
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) valid_q <= 1'b0;
    else            valid_q <= valid_d;
  end

  always_ff @(posedge i_clock) data_q <= data_d;

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_avail = ~valid_q | i_rd_ready;

endmodule

// File: rtl/rotate.sv
// Barrel rotate of a WIDTH-bit vector; LEFT=0 rotates right (toward bit 0).
module rotate #(
  parameter int WIDTH = 4,
  parameter bit LEFT  = 1'b0
) (
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_amount,
  output logic [WIDTH-1:0]         o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEFT) o_data[i] = i_data[(i - int'(i_amount) + WIDTH) % WIDTH];
      else      o_data[i] = i_data[(i + int'(i_amount)) % WIDTH];
    end
  end

endmodule

// File: rtl/ring_dispatcher.sv
// Round-robin dispatcher: each input word goes to the next available output slot.
module ring_dispatcher
  import ring_dispatcher_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        i_clock,
  input  logic                        i_aresetn,
  input  logic                        i_clear,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_input_valid,
  output logic                        o_input_ready,
  output logic [PORTS*DATA_WIDTH-1:0] o_data,
  output logic [PORTS-1:0]            o_output_valid,
  input  logic [PORTS-1:0]            i_output_ready,
  output logic                        o_accept,
  output logic                        o_transmit
);

  localparam int IDX_W = $clog2(PORTS);

  logic [IDX_W-1:0] last_written_q, last_written_d, start, pick_idx;
  logic [PORTS-1:0] avail, avail_rot, pick_rot, pick, wr_en;
  logic             accept;

  assign start = IDX_W'(wrap_inc(int'(last_written_q), PORTS));

  // Search starts just after the last written port: rotate so it sits at bit 0,
  // take the lowest available, then rotate the one-hot back.
  rotate #(.WIDTH(PORTS), .LEFT(1'b0)) u_rot_in (
    .i_data(avail), .i_amount(start), .o_data(avail_rot)
  );
  onehot_priority_encoder #(.WIDTH(PORTS)) u_enc (
    .i_req(avail_rot), .o_onehot(pick_rot)
  );
  rotate #(.WIDTH(PORTS), .LEFT(1'b1)) u_rot_out (
    .i_data(pick_rot), .i_amount(start), .o_data(pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int p = 0; p < PORTS; p++)
      if (pick[p]) pick_idx = IDX_W'(p);
  end

  assign o_input_ready = |avail;
  assign accept        = i_input_valid & o_input_ready;
  assign wr_en         = {PORTS{accept}} & pick;
  assign o_accept      = accept;
  assign o_transmit    = |(o_output_valid & i_output_ready);

  always_comb begin
    last_written_d = accept ? pick_idx : last_written_q;
    if (i_clear) last_written_d = IDX_W'(PORTS - 1);
  end

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) last_written_q <= IDX_W'(PORTS - 1);
    else            last_written_q <= last_written_d;
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_slot
    ring_dispatcher_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .i_clock    (i_clock),
      .i_aresetn  (i_aresetn),
      .i_clear    (i_clear),
      .i_wr_en    (wr_en[p]),
      .i_wr_data  (i_data),
      .i_rd_ready (i_output_ready[p]),
      .o_valid    (o_output_valid[p]),
      .o_data     (o_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .o_avail    (avail[p])
    );
  end

endmodule

// File: tb/tb_ring_dispatcher.sv
// Bench for ring_dispatcher: directed tables, corner sequences and a random scoreboard run.
module tb_ring_dispatcher;

  localparam int P  = 4;
  localparam int DW = 8;

  logic            i_clock = 1'b0;
  logic            i_aresetn = 1'b0;
  logic            i_clear = 1'b0;
  logic [DW-1:0]   i_data = '0;
  logic            i_input_valid = 1'b0;
  logic            o_input_ready;
  logic [P*DW-1:0] o_data;
  logic [P-1:0]    o_output_valid;
  logic [P-1:0]    i_output_ready = '0;
  logic            o_accept;
  logic            o_transmit;

  ring_dispatcher #(.PORTS(P), .DATA_WIDTH(DW)) dut (
    .i_clock(i_clock), .i_aresetn(i_aresetn), .i_clear(i_clear),
    .i_data(i_data), .i_input_valid(i_input_valid), .o_input_ready(o_input_ready),
    .o_data(o_data), .o_output_valid(o_output_valid), .i_output_ready(i_output_ready),
    .o_accept(o_accept), .o_transmit(o_transmit)
  );

  always #5 i_clock = ~i_clock;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: slot occupancy, last written port, per-port expected words.
  logic [P-1:0]  m_vld = '0;
  int            m_lw  = P - 1;
  logic [DW-1:0] sbq [P][$];
  logic          last_acc, last_tx;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic [P-1:0]  rdy;
    int            port;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] port_data(input int p);
    return o_data[p*DW +: DW];
  endfunction

  // Drive one cycle, compare against the model just before the edge, update the model.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [P-1:0] rdy,
                       input logic clr = 1'b0);
    int tgt;
    i_input_valid = v; i_data = d; i_output_ready = rdy; i_clear = clr;
    #1;
    tgt = -1;
    for (int k = 0; k < P; k++) begin
      int p = (m_lw + 1 + k) % P;
      if ((!m_vld[p] || rdy[p]) && tgt < 0) tgt = p;
    end
    check("input_ready", 32'(o_input_ready), 32'(tgt >= 0));
    check("accept", 32'(o_accept), 32'(v && tgt >= 0));
    check("output_valid", 32'(o_output_valid), 32'(m_vld));
    check("transmit", 32'(o_transmit), 32'(|(m_vld & rdy)));
    last_acc = o_accept;
    last_tx  = o_transmit;
    for (int p = 0; p < P; p++) begin
      if (m_vld[p]) check($sformatf("data_p%0d", p), 32'(port_data(p)), 32'(sbq[p][0]));
      if (m_vld[p] && rdy[p]) begin
        void'(sbq[p].pop_front());
        m_vld[p] = 1'b0;
      end
    end
    if (v && tgt >= 0) begin
      sbq[tgt].push_back(d);
      m_vld[tgt] = 1'b1;
      m_lw = tgt;
    end
    if (clr) begin
      for (int p = 0; p < P; p++) sbq[p].delete();
      m_vld = '0;
      m_lw  = P - 1;
    end
    @(posedge i_clock);
    #1;
  endtask

  task automatic expect_port(input string name, input int p, input logic [DW-1:0] d);
    check({name, "_vld"}, 32'(o_output_valid[p]), 32'd1);
    check({name, "_dat"}, 32'(port_data(p)), 32'(d));
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h11, 4'hF, 0};
    tbl[1] = '{1'b1, 8'h22, 4'hF, 1};
    tbl[2] = '{1'b1, 8'h33, 4'hF, 2};
    tbl[3] = '{1'b1, 8'h44, 4'hF, 3};
    tbl[4] = '{1'b1, 8'h55, 4'hF, 0};

    // Reset state
    #3;
    check("rst_output_valid", 32'(o_output_valid), 32'd0);
    check("rst_input_ready", 32'(o_input_ready), 32'd1);
    check("rst_accept", 32'(o_accept), 32'd0);
    check("rst_transmit", 32'(o_transmit), 32'd0);
    #9 i_aresetn = 1'b1;
    @(posedge i_clock); #1;

    // Back-to-back dispatch around the ring
    for (int i = 0; i < 5; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rdy);
      check($sformatf("tbl%0d_accept", i), 32'(last_acc), 32'd1);
      expect_port($sformatf("tbl%0d", i), tbl[i].port, tbl[i].d);
    end
    cycle(1'b0, 8'h00, 4'hF);

    // Fill all ports with downstream stalled, then release port 2
    cycle(1'b0, 8'h00, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'h60 + 8'(i), 4'h0);
      expect_port($sformatf("fill%0d", i), i, 8'h60 + 8'(i));
    end
    check("full_ready", 32'(o_input_ready), 32'd0);
    cycle(1'b1, 8'h64, 4'h0);
    check("full_no_accept", 32'(last_acc), 32'd0);
    cycle(1'b1, 8'h64, 4'b0100);
    check("rel2_accept", 32'(last_acc), 32'd1);
    expect_port("rel2", 2, 8'h64);
    cycle(1'b1, 8'h65, 4'h0);
    check("w6_held", 32'(last_acc), 32'd0);
    cycle(1'b1, 8'h65, 4'hF);
    expect_port("w6", 3, 8'h65);
    cycle(1'b0, 8'h00, 4'hF);

    // Stalled port 1 is skipped
    cycle(1'b0, 8'h00, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hB0 + 8'(i), 4'h0);
    cycle(1'b1, 8'hB4, 4'b1101);
    expect_port("skip_pre", 0, 8'hB4);
    cycle(1'b1, 8'hB5, 4'b1101);
    expect_port("skip1", 2, 8'hB5);
    check("skip1_hold", 32'(port_data(1)), 32'h00B1);
    cycle(1'b0, 8'h00, 4'hF);

    // Simultaneous drain and write on the only available port
    cycle(1'b0, 8'h00, 4'h0, 1'b1);
    cycle(1'b1, 8'h01, 4'h0);
    cycle(1'b1, 8'h02, 4'h0);
    cycle(1'b1, 8'h03, 4'h0);
    cycle(1'b1, 8'hAA, 4'h0);
    expect_port("pre_bb", 3, 8'hAA);
    cycle(1'b1, 8'hBB, 4'b1000);
    check("bb_transmit", 32'(last_tx), 32'd1);
    check("bb_accept", 32'(last_acc), 32'd1);
    expect_port("bb", 3, 8'hBB);
    cycle(1'b0, 8'h00, 4'hF);

    // Clear mid-operation discards buffered words
    cycle(1'b1, 8'hC1, 4'h0);
    cycle(1'b1, 8'hC2, 4'h0);
    cycle(1'b1, 8'hC3, 4'h0);
    cycle(1'b0, 8'h00, 4'h0, 1'b1);
    check("clr_valid", 32'(o_output_valid), 32'd0);
    check("clr_ready", 32'(o_input_ready), 32'd1);
    cycle(1'b1, 8'hC0, 4'h0);
    expect_port("clr_next", 0, 8'hC0);
    cycle(1'b0, 8'h00, 4'hF);

    // Random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      logic [P-1:0] rdy;
      rdy = 4'($urandom_range(0, 15));
      if ((c / 1000) % 2 == 1) rdy = rdy & 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), rdy);
    end
    cycle(1'b0, 8'h00, 4'hF);
    cycle(1'b0, 8'h00, 4'hF);
    check("sb_empty", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
